tile_pixel_packer: RTL and testbench
====================================

# tile_pixel_packer

Serial-to-word packer for the tile graphics path: accepts 4-bit pixels one per enabled 6 MHz cycle and assembles them into 32-bit charram words in the same left-to-right nibble layout the tilemap shift register array unpacks (pixel 0 in [31:28], pixel 7 in [3:0]). It sits between the graphics loader (bubble or CPU decompression path) and the charram write port, issuing one write request per completed word with an auto-incrementing word address. It is the writer end of the tilemap pixel interface.

## Interface
Parameters:
- ADDR_W, 14, charram word-address width; address wraps modulo 2^ADDR_W.

Ports:
- i_EMU_MCLK  in  1  master clock; all state on rising edge.
- i_EMU_RST_n  in  1  asynchronous active-low reset.
- i_EMU_CLK6MPCEN_n  in  1  clock enable, active low; state advances only on enabled edges.
- i_START  in  1  begin new block; loads base address, discards partial word and pending request.
- i_BASEADDR  in  ADDR_W  start word address, sampled with i_START.
- i_FLIP  in  1  nibble order for the whole block, sampled with i_START.
- i_PX_VALID  in  1  pixel present.
- i_PX  in  4  pixel value.
- o_PX_READY  out  1  packer can accept a pixel this enabled edge.
- o_WR_REQ  out  1  o_WR_DATA/o_WR_ADDR valid, held until acknowledged.
- o_WR_ADDR  out  ADDR_W  word address of pending write.
- o_WR_DATA  out  32  packed word.
- i_WR_ACK  in  1  write accepted on this enabled edge.
- o_BUSY  out  1  partial word held or request pending.

## Operation
- Registers: 32-bit pack register, pixel count CNT (0..8), latched flip FLP, output register with REQ flag, address counter ADDR.
- Pixel accepted on enabled edge when i_PX_VALID & o_PX_READY & !i_START.
- Placement: FLP=0 → pixel k of word written to nibble [31-4k:28-4k]; FLP=1 → pixel k to [4k+3:4k].
- o_PX_READY = (CNT != 8); registered-only decode, no combinational path from inputs.
- Transfer to output: when CNT reaches 8 (or is 8) and output is free (REQ=0, or i_WR_ACK on same edge), pack register moves to o_WR_DATA, REQ set, CNT cleared. If the 8th pixel is accepted and output free, transfer happens on that same edge.
- If output busy, CNT stays 8 and o_PX_READY drops until ack.
- On i_WR_ACK with REQ=1: ADDR increments (wraps 2^ADDR_W-1 → 0); REQ cleared unless a new word transfers same edge (REQ stays 1, o_WR_ADDR shows incremented address).
- i_WR_ACK with REQ=0 ignored.
- i_START (enabled edge) has priority: ADDR←i_BASEADDR, FLP←i_FLIP, CNT←0, REQ←0, pixel and ack on that edge ignored.
- o_BUSY = (CNT != 0) | REQ.
- States (derived): IDLE (CNT=0,REQ=0), FILL (0<CNT<8), PEND (REQ=1, CNT<8), STALL (CNT=8, REQ=1).

## Timing
- Reset: o_WR_REQ=0, o_WR_ADDR=0, o_WR_DATA=0, o_PX_READY=1, o_BUSY=0, CNT=0, FLP=0.
- Reset mid-operation discards partial and pending words immediately (asynchronous).
- Latency: 8th pixel accepted at enabled edge N → o_WR_REQ high after edge N (if output free).
- Throughput: one word per 8 enabled cycles sustained when each request acknowledged within 8 enabled cycles; no bubble on simultaneous ack+transfer.
- Disabled edges (i_EMU_CLK6MPCEN_n=1) change nothing; inputs ignored.
- o_WR_DATA/o_WR_ADDR stable while o_WR_REQ=1.

## Configuration
- TILE_PACKER_OPAQUE_FLAG_EN defined: extra output o_WR_OPQ (1 bit), registered with o_WR_DATA, =1 when any nibble of the word is nonzero; reset 0.
- Undefined: port absent, no logic.

## Test plan
- Reset, START base 0x0100 FLIP=0, pixels 1..8, ack immediately → one write 0x12345678 @0x0100, o_BUSY 0 after ack.
- START FLIP=1, pixels 1..8 → 0x87654321.
- 16 pixels continuous, ack withheld 10 enabled cycles → o_PX_READY low once CNT=8; second word 0x9ABCDEF0 issued at 0x0101 on ack edge, no pixel lost.
- START base 0x3FFF, two words → addresses 0x3FFF then 0x0000.
- 3 pixels then START base 0x0200 → partial discarded; next 8 pixels write @0x0200 only.
- Assert reset with REQ=1 → o_WR_REQ 0 immediately; all outputs at reset values; with macro, all-zero word gives o_WR_OPQ=0, word 0x00000010 gives 1.

Source files
------------

// File: rtl/tile_pixel_packer_if.sv
// tile_pixel_packer_if: pixel-stream and charram-write bundle for the tile
// pixel packer. The master modport is the packer side. The slave modport is
// the loader/charram side that drives the pixel stream and the write
// acknowledge.
// Optional feature macro: TILE_PACKER_OPAQUE_FLAG_EN adds o_WR_OPQ.
interface tile_pixel_packer_if #(
  parameter int ADDR_W = 14
);
  logic              i_START;
  logic [ADDR_W-1:0] i_BASEADDR;
  logic              i_FLIP;
  logic              i_PX_VALID;
  logic [3:0]        i_PX;
  logic              o_PX_READY;
  logic              o_WR_REQ;
  logic [ADDR_W-1:0] o_WR_ADDR;
  logic [31:0]       o_WR_DATA;
  logic              i_WR_ACK;
  logic              o_BUSY;
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
  logic              o_WR_OPQ;

  modport master (
    input  i_START, i_BASEADDR, i_FLIP, i_PX_VALID, i_PX, i_WR_ACK,
    output o_PX_READY, o_WR_REQ, o_WR_ADDR, o_WR_DATA, o_BUSY, o_WR_OPQ
  );

  modport slave (
    output i_START, i_BASEADDR, i_FLIP, i_PX_VALID, i_PX, i_WR_ACK,
    input  o_PX_READY, o_WR_REQ, o_WR_ADDR, o_WR_DATA, o_BUSY, o_WR_OPQ
  );
`else
  modport master (
    input  i_START, i_BASEADDR, i_FLIP, i_PX_VALID, i_PX, i_WR_ACK,
    output o_PX_READY, o_WR_REQ, o_WR_ADDR, o_WR_DATA, o_BUSY
  );

  modport slave (
    output i_START, i_BASEADDR, i_FLIP, i_PX_VALID, i_PX, i_WR_ACK,
    input  o_PX_READY, o_WR_REQ, o_WR_ADDR, o_WR_DATA, o_BUSY
  );
`endif
endinterface

// File: rtl/tile_pixel_packer.sv
// tile_pixel_packer: packs 4-bit pixels, one per enabled 6 MHz cycle, into
// 32-bit charram words. In normal order, pixel 0 lands in [31:28]. In flipped
// order, pixel 0 lands in [3:0]. One write request is issued per word, and the
// word address auto-increments on each acknowledge.
// Optional feature macro: TILE_PACKER_OPAQUE_FLAG_EN adds o_WR_OPQ, which is
// set when any nibble of the written word is nonzero.
module tile_pixel_packer #(
  parameter int ADDR_W = 14
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_RST_n,
  input  logic               i_EMU_CLK6MPCEN_n,
  tile_pixel_packer_if.master bus
);

  localparam logic [3:0]        CNT_FULL = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Pixel-stream state
  logic [3:0]        cnt;
  logic              flp;
  logic [31:0]       pack;

  // Output-side state
  logic              req;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] addr;
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
  logic              opq;
`endif

  // Edge qualifiers
  logic              en;
  logic              px_ready;
  logic              take_px;
  logic              ack_hit;
  logic              out_free;
  logic              xfer;
  logic [3:0]        cnt_inc;
  logic [31:0]       pack_nxt;

  // Write one pixel into its nibble slot. The slot depends on the pixel's
  // position in the word and on the block's nibble order.
  function automatic logic [31:0] place_nibble(input logic [31:0] word,
                                               input logic [3:0]  px,
                                               input logic [2:0]  k,
                                               input logic        flip);
    logic [31:0] w;
    logic [4:0]  lsb;
    w   = word;
    lsb = flip ? {k, 2'b00} : (5'd28 - {k, 2'b00});
    w[lsb +: 4] = px;
    return w;
  endfunction

  // Per-edge decode. START wins over pixels and acks on the same edge.
  // Ready is a pure decode of the count register, so it has no input path.
  always_comb begin
    en       = ~i_EMU_CLK6MPCEN_n;
    px_ready = (cnt != CNT_FULL);
    take_px  = en & ~bus.i_START & bus.i_PX_VALID & px_ready;
    ack_hit  = en & ~bus.i_START & bus.i_WR_ACK & req;
    cnt_inc  = take_px ? (cnt + 4'd1) : cnt;
    pack_nxt = take_px ? place_nibble(pack, bus.i_PX, cnt[2:0], flp) : pack;
    out_free = ~req | ack_hit;
    xfer     = en & ~bus.i_START & (cnt_inc == CNT_FULL) & out_free;
  end

  // Control state: pixel count, nibble order, request flag, word address
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      cnt  <= 4'd0;
      flp  <= 1'b0;
      req  <= 1'b0;
      addr <= '0;
    end else if (en) begin
      if (bus.i_START) begin
        cnt  <= 4'd0;
        flp  <= bus.i_FLIP;
        req  <= 1'b0;
        addr <= bus.i_BASEADDR;
      end else begin
        cnt <= xfer ? 4'd0 : cnt_inc;
        if (ack_hit) begin
          addr <= addr + ADDR_ONE;
        end
        if (xfer) begin
          req <= 1'b1;
        end else if (ack_hit) begin
          req <= 1'b0;
        end
      end
    end
  end

  // Pack register. Every slot is rewritten before a word leaves, so this
  // register needs no reset.
  always_ff @(posedge i_EMU_MCLK) begin
    if (take_px) begin
      pack <= pack_nxt;
    end
  end

  // Output word register, loaded together with the accepted 8th pixel
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      wr_data <= 32'd0;
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
      opq     <= 1'b0;
`endif
    end else if (xfer) begin
      wr_data <= pack_nxt;
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
      opq     <= |pack_nxt;
`endif
    end
  end

  assign bus.o_PX_READY = px_ready;
  assign bus.o_WR_REQ   = req;
  assign bus.o_WR_ADDR  = addr;
  assign bus.o_WR_DATA  = wr_data;
  assign bus.o_BUSY     = (cnt != 4'd0) | req;
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
  assign bus.o_WR_OPQ   = opq;
`endif

endmodule

// File: tb/tb_tile_pixel_packer.sv
// Testbench for tile_pixel_packer: table-driven word vectors, directed
// stall/wrap/discard/reset sequences, then randomized traffic compared
// against a queue-based reference model.
module tb_tile_pixel_packer;
  localparam int ADDR_W = 14;
  localparam int N_RAND = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cen_n = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_pixel_packer_if #(.ADDR_W(ADDR_W)) pif();

  tile_pixel_packer #(.ADDR_W(ADDR_W)) dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_RST_n       (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .bus               (pif)
  );

  typedef struct {
    logic        flip;
    logic [13:0] base;
    logic [31:0] seq;       // pixel k is seq[31-4k -: 4]
    logic [31:0] exp_data;
    logic        exp_opq;
  } vec_t;

  vec_t vecs[5];

  // Reference model state
  logic [3:0] m_q[$];
  logic       m_flp;
  logic       m_req;
  logic [31:0] m_data;
  logic       m_opq;
  int         m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input int addr,
                            input logic [31:0] data, input logic ready, input logic busy);
    check({tag, ".req"},   32'(pif.o_WR_REQ),   32'(req));
    check({tag, ".addr"},  32'(pif.o_WR_ADDR),  addr[31:0]);
    check({tag, ".data"},  pif.o_WR_DATA,       data);
    check({tag, ".ready"}, 32'(pif.o_PX_READY), 32'(ready));
    check({tag, ".busy"},  32'(pif.o_BUSY),     32'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [13:0] base, input logic flip);
    pif.i_START    = 1'b1;
    pif.i_BASEADDR = base;
    pif.i_FLIP     = flip;
    tick();
    pif.i_START    = 1'b0;
  endtask

  task automatic push_px(input logic [3:0] p);
    pif.i_PX_VALID = 1'b1;
    pif.i_PX       = p;
    tick();
    pif.i_PX_VALID = 1'b0;
  endtask

  task automatic push8(input logic [31:0] seq);
    for (int k = 0; k < 8; k++) push_px(seq[31-4*k -: 4]);
  endtask

  task automatic ack_once();
    pif.i_WR_ACK = 1'b1;
    tick();
    pif.i_WR_ACK = 1'b0;
  endtask

  // Behavioural model of one enabled edge: a word is a queue of up to 8
  // pixels; a completed word moves out whenever the output slot is empty.
  task automatic model_step();
    logic        acc;
    logic [31:0] w;
    if (!cen_n) begin
      if (pif.i_START) begin
        m_q.delete();
        m_flp  = pif.i_FLIP;
        m_addr = int'(pif.i_BASEADDR);
        m_req  = 1'b0;
      end else begin
        acc = pif.i_PX_VALID && (m_q.size() < 8);
        if (pif.i_WR_ACK && m_req) begin
          m_addr = (m_addr + 1) % (1 << ADDR_W);
          m_req  = 1'b0;
        end
        if (acc) m_q.push_back(pif.i_PX);
        if (m_q.size() == 8 && !m_req) begin
          w = 32'd0;
          for (int k = 0; k < 8; k++)
            w = w | (32'(m_q[k]) << (m_flp ? 4 * k : 28 - 4 * k));
          m_data = w;
          m_opq  = (w != 32'd0);
          m_req  = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] s16;
    logic [3:0]  p;

    vecs[0] = '{1'b0, 14'h0100, 32'h12345678, 32'h12345678, 1'b1};
    vecs[1] = '{1'b1, 14'h0100, 32'h12345678, 32'h87654321, 1'b1};
    vecs[2] = '{1'b1, 14'h02AB, 32'hF0E1D2C3, 32'h3C2D1E0F, 1'b1};
    vecs[3] = '{1'b0, 14'h00F0, 32'h00000000, 32'h00000000, 1'b0};
    vecs[4] = '{1'b0, 14'h00F1, 32'h00000010, 32'h00000010, 1'b1};

    pif.i_START = 1'b0; pif.i_BASEADDR = '0; pif.i_FLIP = 1'b0;
    pif.i_PX_VALID = 1'b0; pif.i_PX = 4'd0; pif.i_WR_ACK = 1'b0;

    // Reset state
    #12;
    check_outs("reset", 1'b0, 0, 32'd0, 1'b1, 1'b0);
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
    check("reset.opq", 32'(pif.o_WR_OPQ), 32'd0);
`endif
    rst_n = 1'b1;
    cen_n = 1'b0;
    tick();

    // Table-driven single words
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].base, vecs[v].flip);
      push8(vecs[v].seq);
      check_outs($sformatf("vec%0d", v), 1'b1, int'(vecs[v].base), vecs[v].exp_data, 1'b1, 1'b1);
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
      check($sformatf("vec%0d.opq", v), 32'(pif.o_WR_OPQ), 32'(vecs[v].exp_opq));
`endif
      ack_once();
      check_outs($sformatf("vec%0d_ack", v), 1'b0, int'(vecs[v].base) + 1, vecs[v].exp_data, 1'b1, 1'b0);
    end

    // 16 pixels back to back with the first ack held off for 10 enabled cycles
    s16 = {32'h12345678, 32'h9ABCDEF0};
    do_start(14'h0100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pif.i_PX_VALID = 1'b1;
      pif.i_PX       = s16[63-4*i -: 4];
      tick();
      if (i == 7) check_outs("stall_w1", 1'b1, 32'h100, 32'h12345678, 1'b1, 1'b1);
    end
    check_outs("stall_full", 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b1);
    pif.i_PX = 4'hF;
    tick();
    tick();
    check_outs("stall_hold", 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b1);
    pif.i_PX_VALID = 1'b0;
    ack_once();
    check_outs("stall_ack1", 1'b1, 32'h101, 32'h9ABCDEF0, 1'b1, 1'b1);
    ack_once();
    check_outs("stall_ack2", 1'b0, 32'h102, 32'h9ABCDEF0, 1'b1, 1'b0);

    // Address wrap at the top of the charram
    do_start(14'h3FFF, 1'b0);
    push8(32'h11111111);
    check_outs("wrap_w1", 1'b1, 32'h3FFF, 32'h11111111, 1'b1, 1'b1);
    ack_once();
    check("wrap_addr0", 32'(pif.o_WR_ADDR), 32'h0000);
    push8(32'h22222222);
    check_outs("wrap_w2", 1'b1, 32'h0000, 32'h22222222, 1'b1, 1'b1);
    ack_once();
    check("wrap_addr1", 32'(pif.o_WR_ADDR), 32'h0001);

    // Partial word discarded by START; disabled edges ignore every input
    do_start(14'h0050, 1'b0);
    push_px(4'h7); push_px(4'h7); push_px(4'h7);
    check_outs("part3", 1'b0, 32'h50, 32'h22222222, 1'b1, 1'b1);
    do_start(14'h0200, 1'b0);
    check_outs("part_restart", 1'b0, 32'h200, 32'h22222222, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      p = 4'hC - 4'(k % 2) * 4'h2;
      push_px((k == 0) ? 4'hC : (k == 1) ? 4'hA : (k == 2) ? 4'hF : 4'hE);
    end
    cen_n = 1'b1;
    pif.i_START = 1'b1; pif.i_BASEADDR = '0; pif.i_PX_VALID = 1'b1;
    pif.i_PX = 4'h5; pif.i_WR_ACK = 1'b1;
    tick();
    tick();
    check_outs("disabled", 1'b0, 32'h200, 32'h22222222, 1'b1, 1'b1);
    cen_n = 1'b0;
    pif.i_START = 1'b0; pif.i_PX_VALID = 1'b0; pif.i_WR_ACK = 1'b0;
    push_px(4'hB); push_px(4'hA); push_px(4'hB); push_px(4'hE);
    check_outs("part_word", 1'b1, 32'h200, 32'hCAFEBABE, 1'b1, 1'b1);
    ack_once();
    check_outs("part_ack", 1'b0, 32'h201, 32'hCAFEBABE, 1'b1, 1'b0);

    // Asynchronous reset while a request is pending
    do_start(14'h0155, 1'b0);
    push8(32'h00000010);
    check("rstmid_pre.req", 32'(pif.o_WR_REQ), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_outs("rstmid", 1'b0, 0, 32'd0, 1'b1, 1'b0);
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
    check("rstmid.opq", 32'(pif.o_WR_OPQ), 32'd0);
`endif
    #2 rst_n = 1'b1;
    tick();
    check_outs("rstmid_post", 1'b0, 0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic against the reference model
    m_q.delete();
    m_flp = 1'b0; m_req = 1'b0; m_data = 32'd0; m_opq = 1'b0; m_addr = 0;
    for (int c = 0; c < N_RAND; c++) begin
      cen_n          = ($urandom_range(0, 3) == 0);
      pif.i_START    = ($urandom_range(0, 63) == 0);
      pif.i_BASEADDR = ($urandom_range(0, 3) == 0) ? 14'h3FFE : 14'($urandom);
      pif.i_FLIP     = 1'($urandom);
      pif.i_PX_VALID = ($urandom_range(0, 3) != 0);
      pif.i_PX       = 4'($urandom);
      pif.i_WR_ACK   = ($urandom_range(0, 2) != 0);
      model_step();
      tick();
      check_outs($sformatf("rnd%0d", c), m_req, m_addr, m_data,
                 m_q.size() != 8, (m_q.size() != 0) || m_req);
`ifdef TILE_PACKER_OPAQUE_FLAG_EN
      check($sformatf("rnd%0d.opq", c), 32'(pif.o_WR_OPQ), 32'(m_opq));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
